change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Return-path counterpart of the coin counter. The coin counter accumulates inserted 100/500 coins; this block takes the change amount computed after coffee selection and physically pays it out. It drives eject pulses to the 500 and 100 coin hoppers one coin at a time, largest coin first. It reports progress (remaining), completion (done) and an unpayable condition (fault) to the top-level coffee machine.

Parameters:
WIDTH, 4, width of change_amount/remaining in units of 100 (matches coin counter total)
BIG_COIN_UNITS, 5, value of a 500 coin expressed in 100-units
PULSE_CYCLES, 2, clock cycles each eject output is held high (>=1)
GAP_CYCLES, 1, idle clock cycles between consecutive coins (>=0)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request payout; sampled only in IDLE
change_amount  input  WIDTH  change to pay, in units of 100 (0..15 -> 0..1500)
hopper_500_empty  input  1  500-coin hopper cannot supply
hopper_100_empty  input  1  100-coin hopper cannot supply
eject_500  output  1  eject one 500 coin while high
eject_100  output  1  eject one 100 coin while high
busy  output  1  payout in progress
done  output  1  one-cycle pulse at end of payout (success or fault)
fault  output  1  remaining change could not be paid; sticky
remaining  output  WIDTH  change still owed, in units of 100

Behaviour:
- Reset (sync, active-high): state IDLE; eject_500=eject_100=busy=done=fault=0; remaining=0; timer cleared. Takes priority over all inputs. Reset mid-payout aborts at once; a coin in progress is truncated.
- All outputs registered; eject_500 and eject_100 never high together.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE: busy=0. start=1 -> remaining<=change_amount, fault<=0, next SELECT. start outside IDLE is ignored (no queuing).
- SELECT (1 cycle, busy=1):
  - remaining==0 -> DONE.
  - else remaining>=BIG_COIN_UNITS and !hopper_500_empty -> coin=500, PULSE.
  - else !hopper_100_empty -> coin=100, PULSE.
  - else fault<=1, DONE. remaining keeps its unpaid value.
- PULSE: selected eject high exactly PULSE_CYCLES cycles. On the last pulse cycle, remaining decreases by BIG_COIN_UNITS or 1 (never underflows, by SELECT rule). Next GAP, or SELECT if GAP_CYCLES==0.
- GAP: ejects low for GAP_CYCLES cycles, then SELECT.
- DONE: done=1 for one cycle, busy=0; next IDLE. fault holds until the next accepted start or reset.
- Hopper flags are sampled only in SELECT. A flag change during PULSE/GAP does not abort the current coin.
- 500 hopper empty with remaining>=5: payout falls back to 100 coins.
- change_amount==0: start -> SELECT -> DONE; done pulses 2 cycles after start, no ejects.
- Latency (defaults, amount=6): start @t0; SELECT t1; eject_500 t2-t3; GAP t4; SELECT t5; eject_100 t6-t7; GAP t8; SELECT t9; done t10.

Decomposition:
- Shared package coffee_pkg: enum dispenser_state_t {IDLE, SELECT, PULSE, GAP, DONE}; enum coin_t {COIN_100, COIN_500}; constant BIG_COIN_UNITS=5 (shared with coin counter and coin comparator).
- One sub-module dispense_timer: loadable down-counter with load value and terminal flag; reused for PULSE and GAP. FSM and remaining register stay in change_dispenser.

Test Plan:
- Reset, then start with amount=6, both hoppers full -> one eject_500 (2 cycles), one eject_100; remaining 6->1->0; done @t10; fault=0.
- amount=13, both full -> ejects in order 500, 500, 100, 100, 100; remaining 13->8->3->2->1->0; done once; eject outputs never overlap.
- amount=7, hopper_500_empty=1 -> seven eject_100 pulses, zero eject_500; done with fault=0.
- amount=7, hopper_500_empty=0, hopper_100_empty=1 -> one eject_500; remaining=2; fault=1 and done in the same cycle. Next start clears fault.
- amount=0 -> no ejects; done 2 cycles after start. Also: start pulsed while busy -> ignored, remaining unaffected.
- reset asserted during the second cycle of an eject_500 -> next cycle all outputs 0, remaining=0, IDLE; a subsequent start(amount=1) pays one 100 coin normally.

Source files
------------

// File: rtl/coffee_pkg.sv
// Types and constants shared by the coffee machine coin path
// (coin counter, coin comparator, change dispenser).
package coffee_pkg;

  localparam int unsigned BIG_COIN_UNITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    DONE
  } dispenser_state_t;

  typedef enum logic {
    COIN_100,
    COIN_500
  } coin_t;

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter; expired_o flags a zero count.
// Used to time both the eject pulse and the inter-coin gap.
module dispense_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_value_i,
  input  logic             tick_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_value_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out change as 500/100 coin eject pulses, largest coin first,
// reporting remaining amount, completion and unpayable faults.
module change_dispenser
  import coffee_pkg::*;
#(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned BIG_COIN_UNITS = coffee_pkg::BIG_COIN_UNITS,
  parameter int unsigned PULSE_CYCLES   = 2,
  parameter int unsigned GAP_CYCLES     = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] change_amount,
  input  logic             hopper_500_empty,
  input  logic             hopper_100_empty,
  output logic             eject_500,
  output logic             eject_100,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [WIDTH-1:0] remaining
);

  localparam int unsigned TIMER_W = (PULSE_CYCLES > GAP_CYCLES) ? $clog2(PULSE_CYCLES + 1)
                                                                 : $clog2(GAP_CYCLES + 1);
  localparam logic [WIDTH-1:0]   BIG_W     = WIDTH'(BIG_COIN_UNITS);
  localparam logic [WIDTH-1:0]   ONE_W     = WIDTH'(1);
  localparam logic [TIMER_W-1:0] PULSE_LD  = TIMER_W'(PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LD    = TIMER_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  dispenser_state_t state_q, state_d;
  coin_t            coin_q, coin_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             fault_q, fault_d;
  logic             eject_500_q, eject_500_d;
  logic             eject_100_q, eject_100_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_tick;
  logic               timer_expired;

  dispense_timer #(
    .Width (TIMER_W)
  ) u_timer (
    .clk_i        (clock),
    .rst_i        (reset),
    .load_i       (timer_load),
    .load_value_i (timer_value),
    .tick_i       (timer_tick),
    .expired_o    (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    coin_d      = coin_q;
    remaining_d = remaining_q;
    fault_d     = fault_q;
    timer_load  = 1'b0;
    timer_value = '0;
    timer_tick  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = change_amount;
          fault_d     = 1'b0;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end else if ((remaining_q >= BIG_W) && !hopper_500_empty) begin
          coin_d      = COIN_500;
          state_d     = PULSE;
          timer_load  = 1'b1;
          timer_value = PULSE_LD;
        end else if (!hopper_100_empty) begin
          coin_d      = COIN_100;
          state_d     = PULSE;
          timer_load  = 1'b1;
          timer_value = PULSE_LD;
        end else begin
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      PULSE: begin
        if (timer_expired) begin
          // SELECT only picks a coin that fits, so this cannot underflow.
          remaining_d = remaining_q - ((coin_q == COIN_500) ? BIG_W : ONE_W);
          if (GAP_CYCLES > 0) begin
            state_d     = GAP;
            timer_load  = 1'b1;
            timer_value = GAP_LD;
          end else begin
            state_d = SELECT;
          end
        end else begin
          timer_tick = 1'b1;
        end
      end
      GAP: begin
        if (timer_expired) begin
          state_d = SELECT;
        end else begin
          timer_tick = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered images of the state being entered.
    eject_500_d = (state_d == PULSE) && (coin_d == COIN_500);
    eject_100_d = (state_d == PULSE) && (coin_d == COIN_100);
    busy_d      = (state_d == SELECT) || (state_d == PULSE) || (state_d == GAP);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      coin_q      <= COIN_100;
      remaining_q <= '0;
      fault_q     <= 1'b0;
      eject_500_q <= 1'b0;
      eject_100_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      coin_q      <= coin_d;
      remaining_q <= remaining_d;
      fault_q     <= fault_d;
      eject_500_q <= eject_500_d;
      eject_100_q <= eject_100_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign eject_500 = eject_500_q;
  assign eject_100 = eject_100_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: coin order, timing, fallback,
// fault, ignored start and mid-payout reset.
module tb_change_dispenser;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] change_amount;
  logic       hopper_500_empty;
  logic       hopper_100_empty;
  logic       eject_500;
  logic       eject_100;
  logic       busy;
  logic       done;
  logic       fault;
  logic [3:0] remaining;

  change_dispenser dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .change_amount    (change_amount),
    .hopper_500_empty (hopper_500_empty),
    .hopper_100_empty (hopper_100_empty),
    .eject_500        (eject_500),
    .eject_100        (eject_100),
    .busy             (busy),
    .done             (done),
    .fault            (fault),
    .remaining        (remaining)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Observations gathered by collect(); cycle k means k cycles after start was sampled.
  int          done_at, done_cnt, e500_cyc, e100_cyc, overlap, coins;
  int          first500, first100;
  logic        fault_at_done, fault_k1;
  logic [31:0] coin_hist, rem_hist;

  task automatic kick(input logic [3:0] amt);
    @(negedge clock);
    change_amount = amt;
    start         = 1'b1;
  endtask

  task automatic collect(input int inj_k, input logic [3:0] inj_amt);
    logic       p500, p100;
    logic [3:0] prev_rem;
    done_at = -1; done_cnt = 0; e500_cyc = 0; e100_cyc = 0; overlap = 0; coins = 0;
    first500 = -1; first100 = -1; fault_at_done = 1'b0; fault_k1 = 1'b0;
    coin_hist = '0; rem_hist = '0; p500 = 1'b0; p100 = 1'b0; prev_rem = '0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      start = (k == inj_k);
      if (k == inj_k) change_amount = inj_amt;
      if (k == 1) begin
        fault_k1 = fault;
        rem_hist = {28'h0, remaining};
        prev_rem = remaining;
      end else if (remaining !== prev_rem) begin
        rem_hist = {rem_hist[27:0], remaining};
        prev_rem = remaining;
      end
      if (eject_500 && eject_100) overlap++;
      if (eject_500) e500_cyc++;
      if (eject_100) e100_cyc++;
      if (eject_500 && !p500) begin
        coins++;
        coin_hist = {coin_hist[27:0], 4'h5};
        if (first500 < 0) first500 = k;
      end
      if (eject_100 && !p100) begin
        coins++;
        coin_hist = {coin_hist[27:0], 4'h1};
        if (first100 < 0) first100 = k;
      end
      p500 = eject_500;
      p100 = eject_100;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at       = k;
          fault_at_done = fault;
        end
      end
      if (done_at >= 0 && k >= done_at + 3) break;
    end
    checks++;
    if (done_at < 0) begin
      errors++;
      $display("FAIL done_timeout: done never seen within 200 cycles, required a done pulse");
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; change_amount = '0;
    hopper_500_empty = 1'b0; hopper_100_empty = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({eject_500, eject_100, busy, done, fault} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000", {eject_500, eject_100, busy, done, fault});
    end
    checks++;
    if (remaining !== 4'd0) begin
      errors++;
      $display("FAIL reset_remaining: got %0d required 0", remaining);
    end
    reset = 1'b0;
  endtask

  task automatic test_amount6;
    kick(4'd6);
    collect(0, 4'd0);
    checks++;
    if (done_at != 10) begin errors++; $display("FAIL a6_done_at: got %0d required 10", done_at); end
    checks++;
    if (first500 != 2 || e500_cyc != 2) begin
      errors++;
      $display("FAIL a6_eject500: first %0d cycles %0d required 2 and 2", first500, e500_cyc);
    end
    checks++;
    if (first100 != 6 || e100_cyc != 2) begin
      errors++;
      $display("FAIL a6_eject100: first %0d cycles %0d required 6 and 2", first100, e100_cyc);
    end
    checks++;
    if (rem_hist !== 32'h610) begin
      errors++; $display("FAIL a6_remaining: got %h required 610", rem_hist);
    end
    checks++;
    if (fault_at_done !== 1'b0) begin errors++; $display("FAIL a6_fault: got %b required 0", fault_at_done); end
  endtask

  task automatic test_amount13;
    kick(4'd13);
    collect(0, 4'd0);
    checks++;
    if (coin_hist !== 32'h55111) begin
      errors++; $display("FAIL a13_order: got %h required 55111", coin_hist);
    end
    checks++;
    if (rem_hist !== 32'hD83210) begin
      errors++; $display("FAIL a13_remaining: got %h required d83210", rem_hist);
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL a13_done_count: got %0d required 1", done_cnt); end
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL a13_overlap: got %0d required 0", overlap); end
    checks++;
    if (done_at != 22) begin errors++; $display("FAIL a13_done_at: got %0d required 22", done_at); end
  endtask

  task automatic test_fallback_100;
    hopper_500_empty = 1'b1;
    kick(4'd7);
    collect(0, 4'd0);
    hopper_500_empty = 1'b0;
    checks++;
    if (coins != 7 || coin_hist !== 32'h1111111) begin
      errors++; $display("FAIL fb_coins: got %0d coins %h required 7 coins 1111111", coins, coin_hist);
    end
    checks++;
    if (e500_cyc != 0) begin errors++; $display("FAIL fb_no500: got %0d required 0", e500_cyc); end
    checks++;
    if (done_at != 30 || fault_at_done !== 1'b0) begin
      errors++;
      $display("FAIL fb_done: at %0d fault %b required 30 and 0", done_at, fault_at_done);
    end
  endtask

  task automatic test_fault;
    hopper_100_empty = 1'b1;
    kick(4'd7);
    collect(0, 4'd0);
    checks++;
    if (coin_hist !== 32'h5 || rem_hist !== 32'h72) begin
      errors++;
      $display("FAIL flt_pay: coins %h rem %h required 5 and 72", coin_hist, rem_hist);
    end
    checks++;
    if (fault_at_done !== 1'b1 || done_at != 6) begin
      errors++;
      $display("FAIL flt_done: fault %b at %0d required 1 at 6", fault_at_done, done_at);
    end
    checks++;
    if (fault !== 1'b1) begin errors++; $display("FAIL flt_sticky: got %b required 1", fault); end
    hopper_100_empty = 1'b0;
    kick(4'd1);
    collect(0, 4'd0);
    checks++;
    if (fault_k1 !== 1'b0 || fault_at_done !== 1'b0) begin
      errors++;
      $display("FAIL flt_clear: t1 %b done %b required 0 and 0", fault_k1, fault_at_done);
    end
  endtask

  task automatic test_zero_and_busy_start;
    kick(4'd0);
    collect(0, 4'd0);
    checks++;
    if (done_at != 2 || coins != 0) begin
      errors++; $display("FAIL zero: done at %0d coins %0d required 2 and 0", done_at, coins);
    end
    kick(4'd6);
    collect(3, 4'd9);
    checks++;
    if (rem_hist !== 32'h610 || done_at != 10) begin
      errors++;
      $display("FAIL busy_start: rem %h done at %0d required 610 and 10", rem_hist, done_at);
    end
  endtask

  task automatic test_reset_mid;
    kick(4'd6);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      start = 1'b0;
    end
    checks++;
    if (eject_500 !== 1'b1) begin errors++; $display("FAIL mid_pre: eject_500 %b required 1", eject_500); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({eject_500, eject_100, busy, done, fault} !== 5'b0 || remaining !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: flags %b rem %0d required 00000 and 0",
               {eject_500, eject_100, busy, done, fault}, remaining);
    end
    reset = 1'b0;
    kick(4'd1);
    collect(0, 4'd0);
    checks++;
    if (coin_hist !== 32'h1 || done_at != 6 || fault_at_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: coins %h done at %0d fault %b required 1, 6, 0",
               coin_hist, done_at, fault_at_done);
    end
  endtask

  initial begin
    test_reset;
    test_amount6;
    test_amount13;
    test_fallback_100;
    test_fault;
    test_zero_and_busy_start;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
